// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - shared widths and latency constants for the FP adder system
package fpadd_pkg;

    localparam int FP_W           = 32;
    localparam int CAPTURE_DEPTH  = 16;
    // Operand register plus adder stages; fpadd_pipelined and the capture side both key off this.
    localparam int FPADD_PIPE_LAT = 5;

    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/fpadd_result_capture_delay.sv
// rtl/fpadd_result_capture_delay.sv - pulse_delay_line: N-stage single-bit strobe delay with async reset
module pulse_delay_line #(
    parameter int N = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < N; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/fpadd_result_capture.sv
// rtl/fpadd_result_capture.sv - captures delayed fpadd results into a readback buffer
// Optional circular-buffer mode: define FPADD_CAPTURE_WRAP_EN.
module fpadd_result_capture
    import fpadd_pkg::*;
#(
    parameter int DEPTH    = CAPTURE_DEPTH,
    parameter int AW       = 4,
    parameter int PIPE_LAT = FPADD_PIPE_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            button,
    input  logic [FP_W-1:0] fp_in,
    input  logic [AW-1:0]   rd_addr,
    output logic [FP_W-1:0] rd_data,
    output logic [FP_W-1:0] last_result,
    output logic [AW:0]     count,
    output logic            full,
    output logic            overflow,
    output logic            capture_pulse
);

    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [FP_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic            capture;
    logic            wr_en;
    logic            wr_done;

    pulse_delay_line #(.N(PIPE_LAT)) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (capture)
    );

    assign full = (count == COUNT_MAX);

`ifdef FPADD_CAPTURE_WRAP_EN
    // When full, wr_ptr already points at the oldest entry, so overwriting it keeps order.
    assign wr_en    = capture;
    assign overflow = 1'b0;
`else
    assign wr_en = capture && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (capture && full) begin
            overflow <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= fp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            last_result   <= '0;
            count         <= '0;
            wr_ptr        <= '0;
            wr_done       <= 1'b0;
            capture_pulse <= 1'b0;
        end else begin
            rd_data       <= mem[rd_addr];
            wr_done       <= wr_en;
            capture_pulse <= wr_done;
            if (wr_en) begin
                last_result <= fp_in;
                wr_ptr      <= wr_ptr + 1'b1;
                if (!full) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpadd_result_capture.sv
// tb/tb_fpadd_result_capture.sv - directed self-checking bench for fpadd_result_capture
module tb_fpadd_result_capture;

    localparam int LAT = 5;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        button;
    logic [31:0] fp_in;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] last_result;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        capture_pulse;

    int n_cmp;
    int n_bad;
    logic [31:0] vals [0:16];

    fpadd_result_capture #(.DEPTH(16), .AW(4), .PIPE_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .fp_in         (fp_in),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .last_result   (last_result),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .capture_pulse (capture_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        button = 1'b0;
        fp_in = JUNK;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Pulse k is sampled at relative edge k and captured at edge k+LAT with vals[k] on fp_in.
    task automatic run_pulses(input int n);
        for (int k = 0; k < n + LAT; k++) begin
            button = (k < n);
            fp_in  = (k >= LAT && (k - LAT) < n) ? vals[k-LAT] : JUNK;
            @(posedge clk);
            #1;
        end
        button = 1'b0;
        fp_in  = JUNK;
    endtask

    task automatic read_at(input logic [3:0] a, output logic [31:0] d);
        rd_addr = a;
        @(posedge clk);
        #1 d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button = 1'b0;
        fp_in = JUNK;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rd_data, last_result, count, full, overflow, capture_pulse} !== 71'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%h last=%h cnt=%0d full=%b ovf=%b cp=%b, want all zero",
                     rd_data, last_result, count, full, overflow, capture_pulse);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] d;
        do_reset();
        vals[0] = 32'h40490FDB;
        run_pulses(1);
        n_cmp++;
        if (count !== 5'd1 || last_result !== 32'h40490FDB) begin
            n_bad++;
            $display("FAIL single_count_last: got cnt=%0d last=%h, want 1 40490fdb", count, last_result);
        end
        n_cmp++;
        if (capture_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse_early: got %b, want 0", capture_pulse);
        end
        read_at(4'd0, d);
        n_cmp++;
        if (capture_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL single_pulse: got %b, want 1", capture_pulse);
        end
        n_cmp++;
        if (d !== 32'h40490FDB) begin
            n_bad++;
            $display("FAIL single_read: got %h, want 40490fdb", d);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (capture_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse_width: got %b, want 0", capture_pulse);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp [0:2];
        exp[0] = 32'h3F800000;
        exp[1] = 32'h40000000;
        exp[2] = 32'h40400000;
        do_reset();
        for (int i = 0; i < 3; i++) vals[i] = exp[i];
        run_pulses(3);
        n_cmp++;
        if (count !== 5'd3 || last_result !== 32'h40400000 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_state: got cnt=%0d last=%h ovf=%b, want 3 40400000 0", count, last_result, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            read_at(4'(i), d);
            n_cmp++;
            if (d !== exp[i]) begin
                n_bad++;
                $display("FAIL b2b_entry%0d: got %h, want %h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        do_reset();
        vals[0] = 32'h11111111;
        run_pulses(1);
        rd_addr = 4'd1;
        vals[0] = 32'h41200000;
        run_pulses(1);
        // mem[1] still holds 40000000 from the back-to-back scenario.
        n_cmp++;
        if (rd_data !== 32'h40000000) begin
            n_bad++;
            $display("FAIL rdw_old: got %h, want 40000000", rd_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rd_data !== 32'h41200000) begin
            n_bad++;
            $display("FAIL rdw_new: got %h, want 41200000", rd_data);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        button = 1'b1;
        fp_in = 32'h12345678;
        @(posedge clk);
        #1 button = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rd_data, last_result, count, full, overflow, capture_pulse} !== 71'd0) begin
            n_bad++;
            $display("FAIL midflight_reset_vals: got rd=%h last=%h cnt=%0d full=%b ovf=%b cp=%b, want all zero",
                     rd_data, last_result, count, full, overflow, capture_pulse);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (capture_pulse !== 1'b0 || count !== 5'd0 || last_result !== 32'd0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midflight_no_capture: got %0d bad cycles, cnt=%0d last=%h, want 0 0 0",
                     seen, count, last_result);
        end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 17; i++) vals[i] = 32'h42000000 | 32'(i);
`ifdef FPADD_CAPTURE_WRAP_EN
        vals[16] = 32'hC0A00000;
`endif
        run_pulses(16);
        n_cmp++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_16: got cnt=%0d full=%b ovf=%b, want 16 1 0", count, full, overflow);
        end
        vals[0] = vals[16];
        run_pulses(1);
        read_at(4'd0, d);
`ifdef FPADD_CAPTURE_WRAP_EN
        n_cmp++;
        if (count !== 5'd16 || overflow !== 1'b0 || last_result !== 32'hC0A00000) begin
            n_bad++;
            $display("FAIL wrap_state: got cnt=%0d ovf=%b last=%h, want 16 0 c0a00000", count, overflow, last_result);
        end
        n_cmp++;
        if (d !== 32'hC0A00000) begin
            n_bad++;
            $display("FAIL wrap_mem0: got %h, want c0a00000", d);
        end
`else
        n_cmp++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_state: got cnt=%0d full=%b ovf=%b, want 16 1 1", count, full, overflow);
        end
        n_cmp++;
        if (last_result !== 32'h4200000F) begin
            n_bad++;
            $display("FAIL ovf_last: got %h, want 4200000f", last_result);
        end
        n_cmp++;
        if (d !== 32'h42000000) begin
            n_bad++;
            $display("FAIL ovf_mem0: got %h, want 42000000", d);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_read_during_write();
        test_reset_midflight();
        test_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpadd_result_capture.md
Name: fpadd_result_capture

Overview:
- Write-side counterpart to the operand data memory in the FP adder system.
- The operand memory feeds operand pairs to fpadd_pipelined on each debounced button pulse. This block captures the matching adder result once the pipeline latency has elapsed and stores it in a small result buffer.
- The buffer can be read back by address for display or debug.
- Sits beside fpadd_pipelined. It takes the same button pulse that advances the operand memory, plus the adder output bus.

Parameters:
- DEPTH, 16, number of 32-bit result entries; must be a power of two.
- AW, 4, address width; must equal log2(DEPTH).
- PIPE_LAT, 5, cycles from the button pulse to a valid adder output for that operand pair (operand register plus adder stages); range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- button  input  1  single-cycle debounced pulse; the same pulse that advances the operand memory.
- fp_in  input  32  adder result bus (fp_out).
- rd_addr  input  AW  readback address.
- rd_data  output  32  registered readback data.
- last_result  output  32  most recently captured result.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- full  output  1  high when count == DEPTH.
- overflow  output  1  sticky; a capture was dropped because the buffer was full.
- capture_pulse  output  1  high for one cycle on the edge after each write.

Behaviour:
- Reset values: rd_data=0, last_result=0, count=0, full=0, overflow=0, capture_pulse=0, wr_ptr=0, delay line all zero. Memory contents are not cleared.
- Delay line: PIPE_LAT-bit shift register. Stage 0 loads button; stage i loads stage i-1 on every edge.
- Capture condition: the edge at which the last stage is 1, i.e. edge t+PIPE_LAT for a pulse sampled at edge t.
- On capture, these updates happen on the same edge:
  - fp_in is written to mem[wr_ptr];
  - last_result <= fp_in;
  - wr_ptr increments modulo DEPTH;
  - count increments.
- capture_pulse is a registered copy of the capture condition, one cycle after the write.
- Back-to-back pulses, including pulses on consecutive cycles, are each captured independently in order. No pulse is lost while the buffer is not full.
- Full, without the optional feature:
  - a capture while count == DEPTH writes nothing;
  - wr_ptr, count and last_result are unchanged;
  - overflow is set and stays set until rst.
- full is combinational from count.
- Readback: rd_data <= mem[rd_addr] every edge (1-cycle latency).
  - A read and write to the same address on the same edge returns the old data.
  - rd_addr >= count returns stale memory contents; this is not an error.
- Reset mid-operation: in-flight delay-line pulses are discarded, so no capture happens after rst deasserts for pulses sampled before it.
- fp_in is sampled only on capture edges; its value in other cycles is ignored.

Optional Feature:
- Macro: FPADD_CAPTURE_WRAP_EN.
- Defined: the buffer becomes circular.
  - A capture when full overwrites mem[wr_ptr], which holds the oldest entry.
  - wr_ptr advances, count stays at DEPTH, last_result updates, capture_pulse fires.
  - overflow is tied to 0.
- Undefined: the drop-and-flag behaviour above applies.

Decomposition:
- Shared package fpadd_pkg holds:
  - FP_W = 32;
  - default CAPTURE_DEPTH = 16;
  - FPADD_PIPE_LAT, the single source of truth used by both fpadd_pipelined and this block.
- One natural sub-module: pulse_delay_line, a parameterised N-stage single-bit shift register with async reset. It is reusable for other latency-matching strobes.
- The memory is inferred inline as a register array with one synchronous write port and one registered read port.

Test Plan:
- Single capture:
  - Stimulus: after reset, pulse button at edge 10 and drive fp_in=32'h40490FDB at edge 15.
  - Required response: mem[0]=32'h40490FDB, count=1, capture_pulse high after edge 16, and rd_addr=0 gives rd_data=32'h40490FDB one cycle later.
- Back-to-back:
  - Stimulus: pulses on 3 consecutive edges, with fp_in = 32'h3F800000, 32'h40000000, 32'h40400000 on the three capture edges.
  - Required response: entries 0..2 hold those values in order, count=3, last_result=32'h40400000.
- Fill and overflow (macro undefined):
  - Stimulus: 17 pulses.
  - Required response: count=16, full=1, overflow=1, mem[0] still holds the first value, last_result equals the 16th value.
- Wrap (FPADD_CAPTURE_WRAP_EN defined):
  - Stimulus: 17 pulses, with the 17th value = 32'hC0A00000.
  - Required response: mem[0]=32'hC0A00000, count=16, overflow=0.
- Reset mid-flight:
  - Stimulus: pulse button, then assert rst 2 cycles later for 1 cycle.
  - Required response: no capture occurs, count=0, and all outputs are at reset values.
- Read-during-write:
  - Stimulus: rd_addr=1 held while the second capture writes 32'h41200000.
  - Required response: rd_data shows the old contents on that edge and 32'h41200000 on the next.
